// File: rtl/rect_fill_engine.sv
// rect_fill_engine: queues filled-rectangle commands in a small FIFO and
// rasterizes each one into a single framebuffer pixel write per clock.
// Optional screen-bound clipping is compiled in with the macro RECT_CLIP_EN.
module rect_fill_engine #(
   parameter int FIFO_DEPTH = 4,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [10:0] cmd_x0,
   input  logic [10:0] cmd_y0,
   input  logic [10:0] cmd_x1,
   input  logic [10:0] cmd_y1,
   input  logic        cmd_color,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        pixel_color,
   output logic        pixel_write,
   output logic        busy,
   output logic        done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ZERO  = '0;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
`ifdef RECT_CLIP_EN
   localparam logic [10:0]   XLIM_C    = 11'(SCREEN_W);
   localparam logic [10:0]   YLIM_C    = 11'(SCREEN_H);
   localparam logic [10:0]   XMAX_C    = 11'(SCREEN_W - 1);
   localparam logic [10:0]   YMAX_C    = 11'(SCREEN_H - 1);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DRAW = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [44:0]   fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [44:0]   head_q, head_d;      // {color, x0, y0, x1, y1} of the popped command
   logic [10:0]   xl_q, xl_d, xr_q, xr_d, yb_q, yb_d;
   logic [10:0]   cx_q, cx_d, cy_q, cy_d;
   logic          color_q, color_d;
   logic          done_q, done_d;
   logic          push_s, pop_s, drop_s;
   logic [10:0]   nxl_s, nxr_s, nyt_s, nyb_s;

   // A full FIFO refuses pushes even if the engine pops on the same edge.
   assign cmd_ready   = (count_q != DEPTH_C);
   assign push_s      = cmd_valid && cmd_ready;
   assign pop_s       = (state_q == IDLE) && (count_q != CNT_ZERO);

   assign x           = cx_q;
   assign y           = cy_q;
   assign pixel_color = color_q;
   assign pixel_write = (state_q == DRAW);
   assign done        = done_q;
   assign busy        = (state_q != IDLE) || (count_q != CNT_ZERO);

   // Normalize the popped corners into left/right/top/bottom bounds, optionally clipped.
   always_comb begin
      nxl_s  = (head_q[43:33] < head_q[21:11]) ? head_q[43:33] : head_q[21:11];
      nxr_s  = (head_q[43:33] < head_q[21:11]) ? head_q[21:11] : head_q[43:33];
      nyt_s  = (head_q[32:22] < head_q[10:0])  ? head_q[32:22] : head_q[10:0];
      nyb_s  = (head_q[32:22] < head_q[10:0])  ? head_q[10:0]  : head_q[32:22];
      drop_s = 1'b0;
`ifdef RECT_CLIP_EN
      if (nxr_s > XMAX_C) begin
         nxr_s = XMAX_C;
      end else begin
         nxr_s = nxr_s;
      end
      if (nyb_s > YMAX_C) begin
         nyb_s = YMAX_C;
      end else begin
         nyb_s = nyb_s;
      end
      if ((nxl_s >= XLIM_C) || (nyt_s >= YLIM_C)) begin
         drop_s = 1'b1;
      end else begin
         drop_s = 1'b0;
      end
`endif
   end

   // Next-state logic for the FIFO bookkeeping and the IDLE/LOAD/DRAW scanner.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      xl_d     = xl_q;
      xr_d     = xr_q;
      yb_d     = yb_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      color_d  = color_q;
      done_d   = 1'b0;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (pop_s) begin
               head_d   = fifo_q[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               state_d  = LOAD;
            end else begin
               state_d  = IDLE;
            end
         end
         LOAD: begin
            if (drop_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               xl_d    = nxl_s;
               xr_d    = nxr_s;
               yb_d    = nyb_s;
               cx_d    = nxl_s;
               cy_d    = nyt_s;
               color_d = head_q[44];
               state_d = DRAW;
            end
         end
         DRAW: begin
            if ((cx_q == xr_q) && (cy_q == yb_q)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (cx_q == xr_q) begin
               cx_d    = xl_q;
               cy_d    = cy_q + 11'd1;
            end else begin
               cx_d    = cx_q + 11'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Command storage; contents need no reset because reset empties the pointers.
   always_ff @(posedge CLOCK_50) begin
      if (push_s) begin
         fifo_q[wr_ptr_q] <= {cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1};
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= 45'd0;
         xl_q     <= 11'd0;
         xr_q     <= 11'd0;
         yb_q     <= 11'd0;
         cx_q     <= 11'd0;
         cy_q     <= 11'd0;
         color_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         xl_q     <= xl_d;
         xr_q     <= xr_d;
         yb_q     <= yb_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         color_q  <= color_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: directed bench with a scoreboard of expected pixel
// writes and done pulses; honours RECT_CLIP_EN for the clipping cases.
module tb_rect_fill_engine;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
   logic        cmd_color;
   logic [10:0] x, y;
   logic        pixel_color, pixel_write, busy, done;

   int checks = 0;
   int errors = 0;

   // entry = {is_done, color, x, y}
   logic [23:0] exp_q[$];

   rect_fill_engine #(.FIFO_DEPTH(4), .SCREEN_W(640), .SCREEN_H(480)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_x0     (cmd_x0),
      .cmd_y0     (cmd_y0),
      .cmd_x1     (cmd_x1),
      .cmd_y1     (cmd_y1),
      .cmd_color  (cmd_color),
      .x          (x),
      .y          (y),
      .pixel_color(pixel_color),
      .pixel_write(pixel_write),
      .busy       (busy),
      .done       (done)
   );

   // 50 MHz-style free-running clock
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_push(input logic [10:0] a, input logic [10:0] b,
                             input logic [10:0] c, input logic [10:0] d, input logic col);
      logic [10:0] xl, xr, yt, yb;
      logic        drop;
      xl = (a < c) ? a : c;
      xr = (a < c) ? c : a;
      yt = (b < d) ? b : d;
      yb = (b < d) ? d : b;
      drop = 1'b0;
`ifdef RECT_CLIP_EN
      if (xr > 11'd639) xr = 11'd639;
      if (yb > 11'd479) yb = 11'd479;
      if ((xl >= 11'd640) || (yt >= 11'd480)) drop = 1'b1;
`endif
      if (!drop) begin
         for (int j = int'(yt); j <= int'(yb); j++) begin
            for (int i = int'(xl); i <= int'(xr); i++) begin
               exp_q.push_back({1'b0, col, 11'(i), 11'(j)});
            end
         end
      end
      exp_q.push_back({1'b1, 23'd0});
   endtask

   task automatic send(input logic [10:0] a, input logic [10:0] b,
                       input logic [10:0] c, input logic [10:0] d, input logic col);
      int t;
      @(negedge CLOCK_50);
      cmd_x0 = a; cmd_y0 = b; cmd_x1 = c; cmd_y1 = d; cmd_color = col;
      cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 2000) begin
         @(negedge CLOCK_50);
         t++;
      end
      chk("send_timeout", 32'(t < 2000), 32'd1);
      @(posedge CLOCK_50);
      model_push(a, b, c, d, col);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      @(negedge CLOCK_50);
      while (busy && t < 6000) begin
         @(negedge CLOCK_50);
         t++;
      end
      chk({tag, "_idle_timeout"}, 32'(t < 6000), 32'd1);
      @(negedge CLOCK_50);
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic drive_bp(input int i);
      if (i == 0) begin
         cmd_x0 = 11'd0; cmd_y0 = 11'd10; cmd_x1 = 11'd99; cmd_y1 = 11'd10; cmd_color = 1'b1;
      end else begin
         cmd_x0 = 11'(i * 4); cmd_y0 = 11'd20;
         cmd_x1 = 11'(i * 4 + 1); cmd_y1 = 11'd21; cmd_color = 1'(i % 2);
      end
   endtask

   // Scoreboard monitor: every pixel write and done pulse must match the queue head.
   always @(negedge CLOCK_50) begin
      logic [23:0] e;
      if (!reset && (pixel_write || done)) begin
         if (pixel_write) chk("write_while_busy", 32'(busy), 32'd1);
         if (done) chk("done_without_write", 32'(pixel_write), 32'd0);
         if (exp_q.size() == 0) begin
            chk("spurious_output", {30'd0, pixel_write, done}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("scoreboard", done ? 32'h0080_0000 : {9'd0, pixel_color, x, y},
                {8'd0, e});
         end
      end
   end

   initial begin
      int acc, t, n;
      logic pd, pp;
      reset = 1'b1; cmd_valid = 1'b0;
      cmd_x0 = 11'd0; cmd_y0 = 11'd0; cmd_x1 = 11'd0; cmd_y1 = 11'd0; cmd_color = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1 reset = 1'b0;

      // Reset state
      @(negedge CLOCK_50);
      chk("rst_pixel_write", 32'(pixel_write), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_xy", {10'd0, x, y}, 32'd0);
      chk("rst_color", 32'(pixel_color), 32'd0);

      // Single rectangle with latency check
      send(11'd2, 11'd3, 11'd4, 11'd4, 1'b1);
      @(negedge CLOCK_50);
      chk("lat_n1_busy", 32'(busy), 32'd1);
      chk("lat_n1_pw", 32'(pixel_write), 32'd0);
      @(negedge CLOCK_50);
      chk("lat_n2_pw", 32'(pixel_write), 32'd0);
      @(negedge CLOCK_50);
      chk("lat_n3_pw", 32'(pixel_write), 32'd1);
      chk("lat_first_xy", {10'd0, x, y}, {10'd0, 11'd2, 11'd3});
      wait_idle("single_rect");

      // Swapped corners
      send(11'd9, 11'd7, 11'd5, 11'd7, 1'b0);
      wait_idle("swapped");

      // Single pixel
      send(11'd0, 11'd0, 11'd0, 11'd0, 1'b1);
      wait_idle("single_pixel");

      // Backpressure: hold valid while a 100x1 rectangle draws
      acc = 0;
      @(negedge CLOCK_50);
      for (int k = 0; k < 10; k++) begin
         drive_bp(acc);
         cmd_valid = 1'b1;
         if (!cmd_ready) break;
         @(posedge CLOCK_50);
         model_push(cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color);
         acc++;
         @(negedge CLOCK_50);
      end
      chk("bp_accepts", 32'(acc), 32'd5);
      t = 0;
      pd = done; pp = pixel_write;
      while (!cmd_ready && t < 400) begin
         pd = done; pp = pixel_write;
         @(negedge CLOCK_50);
         t++;
      end
      chk("bp_ready_timeout", 32'(t < 400), 32'd1);
      chk("bp_rise_pw", 32'(pixel_write), 32'd0);
      chk("bp_rise_prev_done", 32'(pd), 32'd1);
      chk("bp_rise_prev_pw", 32'(pp), 32'd0);
      @(posedge CLOCK_50);
      model_push(cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color);
      #1 cmd_valid = 1'b0;
      @(negedge CLOCK_50);
      chk("bp_gap_first_pixel", 32'(pixel_write), 32'd1);
      wait_idle("backpressure");

      // Reset during pixel 10 of a 50x50 rectangle with two commands queued
      send(11'd0, 11'd0, 11'd49, 11'd49, 1'b1);
      send(11'd100, 11'd100, 11'd101, 11'd101, 1'b0);
      send(11'd200, 11'd200, 11'd200, 11'd200, 1'b1);
      n = 0; t = 0;
      while (n < 10 && t < 100) begin
         @(negedge CLOCK_50);
         if (pixel_write) n++;
         t++;
      end
      chk("rst_mid_reach_pix10", 32'(n), 32'd10);
      reset = 1'b1;
      @(posedge CLOCK_50);
      #1 reset = 1'b0;
      exp_q.delete();
      @(negedge CLOCK_50);
      chk("rstmid_pw", 32'(pixel_write), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_ready", 32'(cmd_ready), 32'd1);
      chk("rstmid_done", 32'(done), 32'd0);
      for (int k = 0; k < 20; k++) begin
         @(negedge CLOCK_50);
         chk("rstmid_quiet", {30'd0, pixel_write, busy}, 32'd0);
      end

`ifdef RECT_CLIP_EN
      // Clipping to the screen edge and dropping fully off-screen commands
      send(11'd636, 11'd478, 11'd700, 11'd500, 1'b1);
      wait_idle("clip_partial");
      send(11'd640, 11'd0, 11'd650, 11'd5, 1'b1);
      wait_idle("clip_drop");
`endif

      // Engine still functional after mid-draw reset
      send(11'd10, 11'd11, 11'd12, 11'd11, 1'b0);
      wait_idle("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Queues filled-rectangle draw commands (pipes, bird sprite box, ground strip, background wipes) and rasterizes each into one framebuffer pixel write per clock. It sits directly upstream of `VGA_framebuffer` and drives its `x`, `y`, `pixel_color` and `pixel_write` inputs. Game logic pushes rectangles through a valid/ready handshake and does not need to track pixel timing.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; must be a power of 2 and at least 2.
- `SCREEN_W`, default 640: visible width in pixels.
- `SCREEN_H`, default 480: visible height in pixels.

- `CLOCK_50`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: reset, synchronous, active-high; clock `CLOCK_50`.
- `cmd_valid`, input, 1: a command is presented this cycle.
- `cmd_ready`, output, 1: FIFO can accept a command.
- `cmd_x0`, `cmd_y0`, `cmd_x1`, `cmd_y1`, input, 11 each: opposite corners of the rectangle, inclusive, in any order.
- `cmd_color`, input, 1: fill colour.
- `x`, `y`, output, 11 each: pixel coordinate to the framebuffer.
- `pixel_color`, output, 1: pixel colour to the framebuffer.
- `pixel_write`, output, 1: `x`, `y` and `pixel_color` are valid and must be written this cycle.
- `busy`, output, 1: a command is queued or being drawn.
- `done`, output, 1: one-cycle pulse when a command retires.

## Operation
- **Push rule.** A command is pushed on an edge where `cmd_valid && cmd_ready`.
  - `cmd_ready = (count != FIFO_DEPTH)`, derived combinationally from the registered FIFO count.
  - When the FIFO is full, a push is rejected even if a pop occurs on the same edge.
  - A push and a pop on the same edge (FIFO not full) leave `count` unchanged.
- **FIFO storage.** Circular buffer with read and write pointers of width log2(FIFO_DEPTH); pointers wrap naturally. Each entry holds 45 bits (four 11-bit coordinates plus colour).
- **State machine.** States are IDLE, LOAD and DRAW.
  - IDLE: if the FIFO is non-empty, pop the head and go to LOAD. Otherwise stay in IDLE.
  - LOAD: register the normalized bounds `xl = min(x0,x1)`, `xr = max(x0,x1)`, `yt = min(y0,y1)`, `yb = max(y0,y1)`. Set the counters `cx = xl`, `cy = yt`. Latch the colour. Go to DRAW.
  - DRAW: `pixel_write = 1`, `x = cx`, `y = cy`, `pixel_color` = latched colour. Scan is raster order, x fastest:
    - if `cx == xr` and `cy == yb`: go to IDLE and pulse `done` on the following cycle;
    - else if `cx == xr`: `cx = xl`, `cy = cy + 1`;
    - else: `cx = cx + 1`.
- **Arithmetic.** All coordinate arithmetic is 11-bit unsigned. Normalization guarantees `cx` and `cy` never increment past `xr` and `yb`, so they never wrap.
- **busy.** `busy = (state != IDLE) || (count != 0)`.
- **Reset.**
  - Reset mid-operation abandons the current rectangle, empties the FIFO and forces IDLE. `pixel_write` is 0 from the cycle after the reset edge.
  - Output values under reset: `x = 0`, `y = 0`, `pixel_color = 0`, `pixel_write = 0`, `done = 0`, `busy = 0`, `cmd_ready = 1`.

## Timing
- **Pixel count.** A rectangle produces exactly `(xr-xl+1)*(yb-yt+1)` consecutive `pixel_write` cycles.
- **Latency.** For a command accepted at edge N into an empty FIFO with the engine in IDLE:
  - the engine is in LOAD after edge N+1;
  - the first pixel is visible in the cycle after edge N+2.
- **done.** `done` is high for exactly one cycle, the cycle immediately after the last pixel cycle.
- **Back-to-back commands.** Between the last pixel of one rectangle and the first pixel of the next queued rectangle there are two cycles with `pixel_write = 0` (IDLE, then LOAD).
- **Register ownership.** `x`, `y`, `pixel_color` and `pixel_write` are driven from registers or the state register. There is no combinational path from `cmd_*` to the pixel outputs.

## Configuration
- **Macro.** `RECT_CLIP_EN` compiles screen-bound clipping in or out.
- **Defined.** In LOAD:
  - `xr` is clamped to `SCREEN_W-1` and `yb` to `SCREEN_H-1`.
  - If `xl >= SCREEN_W` or `yt >= SCREEN_H`, the command is dropped: LOAD goes to IDLE, `done` pulses on the next cycle, and no pixels are written.
- **Undefined.** Normalized bounds are used unmodified, and every pixel of the rectangle is emitted even when it lies off-screen.

## Test plan
- **Single rectangle.** Push (2,3)-(4,4), colour 1, into an idle engine. Expect 6 writes in order (2,3) (3,3) (4,3) (2,4) (3,4) (4,4), all with colour 1. The first write appears 2 cycles after the accept edge, and `done` pulses exactly once, the cycle after (4,4).
- **Swapped corners.** Push (9,7)-(5,7). Expect writes x = 5..9 at y = 7, 5 pixels.
- **Backpressure.** Hold `cmd_valid` with FIFO_DEPTH = 4 while a 100x1 rectangle draws. Expect `cmd_ready` to drop after 4 more accepts and rise again on the IDLE pop. All queued commands retire in push order with 2-cycle gaps, and `busy` falls only after the last `done`.
- **Reset mid-draw.** Assert `reset` for one cycle during pixel 10 of a 50x50 rectangle with 2 commands queued. Expect `pixel_write = 0` from the next cycle and no further writes, with `busy = 0`, `cmd_ready = 1` and `done = 0`.
- **Single pixel.** Push (0,0)-(0,0). Expect exactly one write at (0,0), followed by `done`.
- **Clipping, `RECT_CLIP_EN` defined.**
  - Push (636,478)-(700,500): expect writes only at x 636..639 for y 478..479, 8 writes.
  - Push (640,0)-(650,5): expect zero writes and one `done` pulse.
